// File: rtl/aamux_pkg.sv
// Shared widths, FSM encoding and protocol-error codes for the AAMUX front-end.
package aamux_pkg;

  localparam int DEF_ADDR_W = 21;
  localparam int DEF_ROW_W  = 11;
  localparam int DEF_COL_W  = 10;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {IDLE, ROW, ADDR, WRITE, READ} state_t;

  localparam logic [2:0] PC_NONE     = 3'd0;
  localparam logic [2:0] PC_WG_LOW   = 3'd1;
  localparam logic [2:0] PC_RC_W_LOW = 3'd2;
  localparam logic [2:0] PC_COL_MSB  = 3'd3;
  localparam logic [2:0] PC_DROP     = 3'd4;

endpackage

// File: rtl/aamux_wr_fifo.sv
// Synchronous write-transaction FIFO; head visible combinationally, zero-latency pop.
// Push is ignored when full unless a pop happens in the same cycle.
module aamux_wr_fifo #(
  parameter int W     = 29,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         wr_en, rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr[AW-1:0]] <= din;
        wptr <= wptr + (AW+1)'(1);
      end
      if (rd_en) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/aamux_bus_if.sv
// AAMUX pin front-end: rebuilds addresses, queues writes for the CUI (drop when full), serves reads on DQ.
// Strobes take SYNC_STAGES+1 cycles to act; optional checker under AAMUX_PROTOCOL_CHECK_EN.
module aamux_bus_if
  import aamux_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int ROW_W       = DEF_ROW_W,
  parameter int COL_W       = DEF_COL_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rp_n,
  input  logic              rc_pin,
  input  logic              w_n_pin,
  input  logic              g_n_pin,
  input  logic [ROW_W-1:0]  a_pin,
  input  logic [DATA_W-1:0] dq_in,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic              wr_drop
`ifdef AAMUX_PROTOCOL_CHECK_EN
  ,
  output logic              proto_err,
  output logic [2:0]        proto_code
`endif
);

  logic [SYNC_STAGES-1:0] rc_sync, w_sync, g_sync;
  logic [SYNC_STAGES:0]   arm;
  logic rc_d, w_d, g_d, rc_s, w_s, g_s, armed;
  logic rc_fall, rc_rise, w_fall, w_rise, g_fall, g_rise;

  state_t state, state_nxt;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [ADDR_W-1:0] addr_cur;
  logic rd_pend, rd_pend_nxt, rd_fire, push, pop, capture, drop_now;
  logic fifo_full, fifo_empty;

  assign rc_s  = rc_sync[SYNC_STAGES-1];
  assign w_s   = w_sync[SYNC_STAGES-1];
  assign g_s   = g_sync[SYNC_STAGES-1];
  // Edges are masked until the synchronizers have flushed out their reset value,
  // so a strobe still held low across reset release is not taken as a fresh edge.
  assign armed   = arm[SYNC_STAGES];
  assign rc_fall = armed &&  rc_d && !rc_s;
  assign rc_rise = armed && !rc_d &&  rc_s;
  assign w_fall  = armed &&  w_d  && !w_s;
  assign w_rise  = armed && !w_d  &&  w_s;
  assign g_fall  = armed &&  g_d  && !g_s;
  assign g_rise  = armed && !g_d  &&  g_s;

  assign addr_cur = {col_q, row_q};
  assign wr_valid = !fifo_empty;
  assign pop      = wr_valid && wr_ready;
  assign drop_now = push && fifo_full && !pop;

  always_comb begin
    state_nxt   = state;
    push        = 1'b0;
    rd_pend_nxt = rd_pend;
    if (rc_fall) begin
      state_nxt = ROW;
    end else begin
      case (state)
        IDLE:    if (w_fall) state_nxt = WRITE;
        ROW:     if (w_fall) state_nxt = WRITE;
                 else if (rc_rise) state_nxt = ADDR;
        ADDR:    if (w_fall) state_nxt = WRITE;
                 else if (g_fall && w_s) state_nxt = READ;
        WRITE:   if (w_rise) begin
                   state_nxt = IDLE;
                   push      = 1'b1;
                 end
        READ:    if (w_fall) state_nxt = WRITE;
                 else if (g_rise) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    // Reads wait behind buffered writes so the CUI sees commands in pin order.
    if (state_nxt != READ)  rd_pend_nxt = 1'b0;
    else if (state != READ) rd_pend_nxt = 1'b1;
    rd_fire = (state_nxt == READ) && rd_pend_nxt && fifo_empty;
    if (rd_fire) rd_pend_nxt = 1'b0;
    capture = (state == READ) && (state_nxt == READ) && rd_valid;
  end

  always_ff @(posedge clk or negedge rp_n) begin
    if (!rp_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rp_n) begin
    if (!rp_n) begin
      rc_sync <= '1;
      w_sync  <= '1;
      g_sync  <= '1;
      rc_d    <= 1'b1;
      w_d     <= 1'b1;
      g_d     <= 1'b1;
      arm     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      rd_pend <= 1'b0;
      rd_req  <= 1'b0;
      rd_addr <= '0;
      dq_out  <= '0;
      dq_oe   <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      rc_sync <= {rc_sync[SYNC_STAGES-2:0], rc_pin};
      w_sync  <= {w_sync[SYNC_STAGES-2:0], w_n_pin};
      g_sync  <= {g_sync[SYNC_STAGES-2:0], g_n_pin};
      rc_d    <= rc_s;
      w_d     <= w_s;
      g_d     <= g_s;
      arm     <= {arm[SYNC_STAGES-1:0], 1'b1};
      if (rc_fall) row_q <= a_pin;
      if (rc_rise) col_q <= a_pin[COL_W-1:0];
      rd_pend <= rd_pend_nxt;
      rd_req  <= rd_fire;
      if (rd_fire) rd_addr <= addr_cur;
      if (capture) dq_out <= rd_data;
      if (state_nxt != READ) dq_oe <= 1'b0;
      else if (capture)      dq_oe <= 1'b1;
      wr_drop <= drop_now;
    end
  end

  aamux_wr_fifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rp_n),
    .push  (push),
    .pop   (pop),
    .din   ({addr_cur, dq_in}),
    .dout  ({wr_addr, wr_data}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef AAMUX_PROTOCOL_CHECK_EN
  logic [2:0] code_now;

  always_comb begin
    code_now = PC_NONE;
    if (armed && !w_s && !g_s)                 code_now = PC_WG_LOW;
    else if ((rc_fall || rc_rise) && !w_s)     code_now = PC_RC_W_LOW;
    else if (rc_rise && !a_pin[ROW_W-1])       code_now = PC_COL_MSB;
    else if (drop_now)                         code_now = PC_DROP;
  end

  always_ff @(posedge clk or negedge rp_n) begin
    if (!rp_n) begin
      proto_err  <= 1'b0;
      proto_code <= PC_NONE;
    end else if (!proto_err && code_now != PC_NONE) begin
      proto_err  <= 1'b1;
      proto_code <= code_now;
    end
  end
`endif

endmodule

// File: doc/aamux_bus_if.md
Name: aamux_bus_if

Overview:
- Front-end of the M50LPW116 model's AAMUX port. It sits directly downstream of the AAMUX stimulus pins and upstream of the command user interface (CUI) and array read path.
- Samples RC, W#, G# and the multiplexed address/data pins in the clk domain and rebuilds full 21-bit addresses from the row and column phases.
- Delivers each write cycle as a buffered {addr, data} transaction to the CUI.
- Issues read requests and drives DQ for read cycles.

Parameters:
- ADDR_W, 21, full memory address width.
- ROW_W, 11, row phase width (addr[10:0]).
- COL_W, 10, column phase width (addr[20:11]; bit ROW_W-1 of the pins is ignored during the column phase).
- DATA_W, 8, data width.
- SYNC_STAGES, 2, synchronizer depth on rc_pin, w_n_pin and g_n_pin.
- FIFO_DEPTH, 2, write-transaction buffer depth (power of 2).

Ports:
- clk  in  1  sampling clock.
- rp_n  in  1  asynchronous active-low reset.
- rc_pin  in  1  row/column strobe.
- w_n_pin  in  1  write strobe, active low.
- g_n_pin  in  1  output enable, active low.
- a_pin  in  ROW_W  multiplexed address pins.
- dq_in  in  DATA_W  DQ pins, input side.
- dq_out  out  DATA_W  DQ drive value.
- dq_oe  out  1  DQ output enable.
- wr_valid  out  1  write transaction available to the CUI.
- wr_ready  in  1  CUI accepts the transaction.
- wr_addr  out  ADDR_W  address of the head transaction.
- wr_data  out  DATA_W  data of the head transaction.
- rd_req  out  1  one-cycle read request pulse.
- rd_addr  out  ADDR_W  address for the read.
- rd_data  in  DATA_W  array or status read data.
- rd_valid  in  1  rd_data valid, one cycle.
- wr_drop  out  1  one-cycle pulse: write lost because the FIFO was full.

Behaviour:
- Reset: rp_n is asynchronous and active-low. All registers clear. Outputs reset to: dq_oe=0, dq_out=0, wr_valid=0, rd_req=0, wr_drop=0, rd_addr=0. FIFO is emptied. Synchronizers reset to the inactive level (rc=1, w_n=1, g_n=1). FSM goes to IDLE.
- Edge detection: edges are taken on the last synchronizer stage. a_pin and dq_in are sampled in the same cycle the edge is detected. The stimulus holds them at least 50 ns around each edge, so they need no synchronization.
- Row latch: rc falling edge latches row_q <= a_pin.
- Column latch: rc rising edge latches col_q <= a_pin[COL_W-1:0]. The latched address is {col_q, row_q}.
- FSM states and transitions:
  - IDLE -> ROW on rc fall.
  - ROW -> ADDR on rc rise.
  - ADDR -> WRITE on w_n fall; ADDR -> READ on g_n fall.
  - WRITE -> IDLE on w_n rise. The write is committed at this point: push {addr, dq_in}.
  - READ: rd_req pulses 1 cycle on entry, with rd_addr = latched address. When rd_valid arrives, capture dq_out <= rd_data. dq_oe = 1 from capture until the g_n rise. On g_n rise go to IDLE with dq_oe=0 in the same cycle.
- Command-only cycles: when the address pins are Z, row_q and col_q still latch, and the write is pushed normally. The CUI ignores the address for pure commands.
- w_n falling edge seen in ROW or IDLE, i.e. rc not yet risen: allowed. Go to WRITE; the commit uses the current latches.
- Any new rc fall from any state restarts at ROW.
- FIFO handshake: one write pushed per commit. wr_valid = !empty. A pop occurs when wr_valid && wr_ready. Push and pop in the same cycle are allowed, including when full.
- Full with no pop: the commit is discarded and wr_drop pulses. FIFO contents are unchanged.
- Read while a write is still buffered: rd_req is held off until the FIFO is empty, which preserves CUI command order. rd_req fires the cycle after empty.
- w_n and g_n both low: the write wins. READ is not entered, and dq_oe stays 0.

Optional Feature:
- AAMUX_PROTOCOL_CHECK_EN defined: adds a sticky output proto_err (1 bit, reset 0) and a 3-bit proto_code. Codes:
  - 1 = w_n and g_n low together.
  - 2 = rc edge while w_n is low.
  - 3 = column-phase a_pin[ROW_W-1] != 1.
  - 4 = wr_drop.
  - proto_code records the first error only; both clear only on reset.
- Undefined: proto_err and proto_code are absent, and no check logic is built.

Decomposition:
- Shared package aamux_pkg: the ADDR_W, ROW_W, COL_W and DATA_W defaults; the FSM state encoding {IDLE, ROW, ADDR, WRITE, READ}; the proto_code constants.
- One sub-module: aamux_wr_fifo (parameterised sync FIFO with push, pop, full, empty).
- The edge synchronizers stay inline.

Test Plan:
- Program data cycle for addr 21'h1AB650, data 8'h22 -> row_q=11'h650, col_q=10'h356, one push; wr_addr=21'h1AB650, wr_data=8'h22.
- Chip erase sequence: command 8'h80 then 8'h10 with wr_ready=0 -> two entries buffered. Raising wr_ready pops 80 then 10 in order; wr_valid falls after the second pop.
- Third write with wr_ready=0 and FIFO full -> wr_drop pulses once; the head entry stays 8'h80.
- Read of 21'h1AB652 with rd_data=8'hCE after 3 cycles -> one rd_req with rd_addr=21'h1AB652. dq_oe=1 with dq_out=8'hCE until g_n rises, then dq_oe=0 in the same cycle.
- Read issued while one write is pending and wr_ready is delayed by 5 cycles -> rd_req appears only the cycle after the FIFO empties.
- rp_n asserted mid-WRITE (w_n low) -> all outputs reset immediately. After release, the w_n rise produces no push and the FSM stays in IDLE.
